// File: rtl/vx_gpr_arbiter.sv
// Round-robin sharing of the GPR read ports among NUM_REQS requesters, with response steering
// and a post-reset zero-fill of every warp/register entry through the write port.
module vx_gpr_arbiter #(
  parameter int unsigned NUM_REQS    = 2,
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned WIDW        = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQS-1:0]      req_valid,
  input  logic [NUM_REQS*WIDW-1:0] req_wid,
  input  logic [NUM_REQS*5-1:0]    req_rs1,
  input  logic [NUM_REQS*5-1:0]    req_rs2,
  input  logic [NUM_REQS*5-1:0]    req_rs3,
  output logic [NUM_REQS-1:0]      req_ready,
  output logic                     rsp_valid,
  output logic [NUM_REQS-1:0]      rsp_sel,
  input  logic                     rsp_ready,
  output logic [WIDW-1:0]          gpr_wid,
  output logic [4:0]               gpr_rs1,
  output logic [4:0]               gpr_rs2,
  output logic [4:0]               gpr_rs3,
  input  logic                     wb_in_valid,
  input  logic [WIDW-1:0]          wb_in_wid,
  input  logic [4:0]               wb_in_rd,
  input  logic [NUM_THREADS-1:0]   wb_in_tmask,
  output logic                     wb_in_ready,
  output logic                     wb_out_valid,
  output logic [WIDW-1:0]          wb_out_wid,
  output logic [4:0]               wb_out_rd,
  output logic [NUM_THREADS-1:0]   wb_out_tmask,
  output logic                     wb_out_zero,
  output logic                     init_busy
);

  localparam int unsigned CNTW = WIDW + 5;
  localparam int unsigned PTRW = $clog2(NUM_REQS);
  localparam logic [CNTW-1:0] CntLast  = CNTW'(NUM_WARPS * NUM_REGS - 1);
  localparam logic [PTRW:0]   NumReqsW = (PTRW + 1)'(NUM_REQS);
  localparam logic [PTRW-1:0] PtrLast  = PTRW'(NUM_REQS - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                r_state, w_state_next;
  logic [CNTW-1:0]       r_cnt;
  logic [PTRW-1:0]       r_ptr;
  logic [WIDW-1:0]       r_hold_wid;
  logic [4:0]            r_hold_rs1, r_hold_rs2, r_hold_rs3;
  logic                  r_rsp_valid;
  logic [NUM_REQS-1:0]   r_rsp_sel;

  logic                  w_run, w_hold, w_grant;
  logic [PTRW-1:0]       w_idx;
  logic [PTRW:0]         w_sum;
  logic [NUM_REQS-1:0]   w_grant_oh;

  assign w_run  = (r_state == StRun);
  assign w_hold = r_rsp_valid && !rsp_ready;

  // Scan from r_ptr upward with wrap; first valid requester wins.
  always_comb begin
    w_grant = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    if (w_run && !w_hold) begin
      for (int k = 0; k < NUM_REQS; k++) begin
        w_sum = {1'b0, r_ptr} + (PTRW + 1)'(k);
        if (w_sum >= NumReqsW) w_sum = w_sum - NumReqsW;
        if (!w_grant && req_valid[w_sum[PTRW-1:0]]) begin
          w_grant = 1'b1;
          w_idx   = w_sum[PTRW-1:0];
        end
      end
    end
  end

  assign w_grant_oh = w_grant ? (NUM_REQS'(1) << w_idx) : '0;
  assign req_ready  = w_grant_oh;

  // Without a fresh grant the held address is replayed so the read data tracks writes.
  always_comb begin
    gpr_wid = r_hold_wid;
    gpr_rs1 = r_hold_rs1;
    gpr_rs2 = r_hold_rs2;
    gpr_rs3 = r_hold_rs3;
    if (w_grant) begin
      gpr_wid = req_wid[w_idx*WIDW +: WIDW];
      gpr_rs1 = req_rs1[w_idx*5 +: 5];
      gpr_rs2 = req_rs2[w_idx*5 +: 5];
      gpr_rs3 = req_rs3[w_idx*5 +: 5];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sel   = r_rsp_sel;

  always_comb begin
    w_state_next = r_state;
    wb_in_ready  = 1'b0;
    wb_out_valid = 1'b1;
    wb_out_wid   = r_cnt[CNTW-1:5];
    wb_out_rd    = r_cnt[4:0];
    wb_out_tmask = '1;
    wb_out_zero  = 1'b1;
    init_busy    = 1'b1;
    unique case (r_state)
      StInit: begin
        if (r_cnt == CntLast) w_state_next = StRun;
      end
      StRun: begin
        wb_in_ready  = 1'b1;
        wb_out_valid = wb_in_valid;
        wb_out_wid   = wb_in_wid;
        wb_out_rd    = wb_in_rd;
        wb_out_tmask = wb_in_tmask;
        wb_out_zero  = 1'b0;
        init_busy    = 1'b0;
      end
      default: w_state_next = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StInit;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_hold_wid  <= '0;
      r_hold_rs1  <= '0;
      r_hold_rs2  <= '0;
      r_hold_rs3  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sel   <= '0;
    end else begin
      r_state    <= w_state_next;
      if (r_state == StInit) r_cnt <= r_cnt + CNTW'(1);
      r_hold_wid <= gpr_wid;
      r_hold_rs1 <= gpr_rs1;
      r_hold_rs2 <= gpr_rs2;
      r_hold_rs3 <= gpr_rs3;
      if (w_grant) begin
        r_ptr       <= (w_idx == PtrLast) ? '0 : w_idx + PTRW'(1);
        r_rsp_valid <= 1'b1;
        r_rsp_sel   <= w_grant_oh;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/vx_gpr_arbiter.md
# vx_gpr_arbiter

- Sits in front of the per-core GPR stage and shares its single read-port set (rs1/rs2/rs3) among `NUM_REQS` requesters using round-robin arbitration.
- Tracks the one-cycle GPR read latency and steers each response back to the requester that was granted.
- After reset, runs an initialization sequence that zero-fills every warp/register entry through the write port.
- During initialization, all reads and external writebacks are blocked.

## Interface
Parameters:
- `NUM_REQS`, 2: number of read requesters; must be ≥ 2.
- `NUM_WARPS`, 4: warps per core. `WIDW = $clog2(NUM_WARPS)`.
- `NUM_REGS`, 32: registers per warp; 5-bit register index.
- `NUM_THREADS`, 4: lanes; width of the writeback tmask.

Ports (per-requester buses are flattened, requester 0 in the LSBs):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQS  read request per requester.
- `req_wid`  in  NUM_REQS*WIDW  warp id per requester.
- `req_rs1`, `req_rs2`, `req_rs3`  in  NUM_REQS*5 each  source register indices.
- `req_ready`  out  NUM_REQS  one-hot grant; a request is accepted when valid&&ready.
- `rsp_valid`  out  1  GPR read data for the granted request is on the GPR response bus.
- `rsp_sel`  out  NUM_REQS  one-hot owner of the current response.
- `rsp_ready`  in  1  the owner consumes the response.
- `gpr_wid`  out  WIDW  read warp id driven to the GPR stage.
- `gpr_rs1`, `gpr_rs2`, `gpr_rs3`  out  5 each  read register indices driven to the GPR stage.
- `wb_in_valid`  in  1  upstream writeback valid.
- `wb_in_wid`  in  WIDW  upstream writeback warp id.
- `wb_in_rd`  in  5  upstream writeback destination register.
- `wb_in_tmask`  in  NUM_THREADS  upstream writeback thread mask.
- `wb_in_ready`  out  1  upstream writeback ready.
- `wb_out_valid`  out  1  writeback valid to the GPR stage.
- `wb_out_wid`  out  WIDW  writeback warp id to the GPR stage.
- `wb_out_rd`  out  5  writeback register to the GPR stage.
- `wb_out_tmask`  out  NUM_THREADS  writeback thread mask to the GPR stage.
- `wb_out_zero`  out  1  the GPR data mux selects zero data instead of writeback data.
- `init_busy`  out  1  high while the zero-fill is in progress.

## Operation
FSM with two states: INIT and RUN.

INIT:
- A counter `cnt` of width `WIDW+5` starts at 0 and drives `{wb_out_wid, wb_out_rd} = cnt`, `wb_out_valid = 1`, `wb_out_tmask` all ones, `wb_out_zero = 1`.
- `cnt` increments every cycle.
- When `cnt == NUM_WARPS*NUM_REGS-1`, the FSM moves to RUN on the next edge.
- Address 0 of each warp is also issued; the GPR stage suppresses writes to rd=0, which is legal.
- `req_ready = 0` and `wb_in_ready = 0`.

RUN:
- The write port is a pass-through: `wb_out_* = wb_in_*`, `wb_out_zero = 0`, `wb_in_ready = 1`.
- Arbitration uses a round-robin pointer `ptr`, reset to 0. The grant goes to the first requester with `req_valid` set, searching from `ptr` upward and wrapping.
- A grant is issued only when the arbiter is not holding. Holding means `rsp_valid && !rsp_ready`.
- On a grant to requester `i`:
  - `req_ready[i] = 1`, combinational in the same cycle.
  - The GPR address outputs take requester `i`'s wid/rs1/rs2/rs3, combinationally.
  - `ptr <= (i+1) mod NUM_REQS`.
- The GPR address outputs are also registered as `hold_addr`. While holding, the GPR address outputs equal `hold_addr`, so read data is re-read every cycle and reflects any same-address writes.
- With no grant and no hold, the address outputs keep `hold_addr`.

Responses:
- At the edge following a grant: `rsp_valid <= 1`, `rsp_sel <= onehot(i)`.
- `rsp_valid` clears at the edge after `rsp_ready` is sampled high, unless a new grant occurs in that cycle. A new grant in the `rsp_ready` cycle is allowed, giving back-to-back operation.

Reset:
- Reset asserted in any state (async) immediately forces INIT with `cnt = 0`, `ptr = 0`, and `hold_addr = 0`.
- Any in-flight response is dropped.

## Timing
Reset values (while `reset` = 0):
- `init_busy = 1`, `wb_out_valid = 1` with address 0 and `wb_out_zero = 1`.
- `req_ready = 0`, `wb_in_ready = 0`, `rsp_valid = 0`, `rsp_sel = 0`.
- `gpr_wid = 0`, `gpr_rs* = 0`.

Cycle counts:
- INIT lasts exactly `NUM_WARPS*NUM_REGS` cycles after reset deassertion; with defaults, that is 128 cycles.
- `init_busy` is 0 from the first RUN cycle onward.
- Grant-to-`rsp_valid` latency is 1 cycle.
- Maximum throughput is 1 request per cycle when `rsp_ready` is held high.
- Fairness: any continuously valid requester is granted within `NUM_REQS` grants.

Boundary conditions:
- `rsp_ready` is ignored while `rsp_valid = 0`.
- A `wb_in_valid` pulse during INIT is back-pressured, never dropped.

## Test plan
- Reset release with defaults -> `init_busy` is high for 128 cycles, `{wb_out_wid, wb_out_rd}` sweeps 0..127 with `wb_out_zero = 1`, and all `req_ready` stay 0 throughout.
- RUN, requesters 0 and 1 both continuously valid, `rsp_ready = 1` -> grants alternate 0, 1, 0, 1, and `rsp_sel` follows each grant one cycle later.
- Requester 1 only, wid=2, rs1=5, rs2=6, rs3=7 -> `gpr_wid = 2` and `gpr_rs1/2/3 = 5/6/7` in the grant cycle, then `rsp_valid = 1` with `rsp_sel = 2'b10` next cycle.
- Response with `rsp_ready` low for 3 cycles while requester 0 is valid -> no grants during those cycles, GPR address outputs stay held, and requester 0 is granted in the cycle `rsp_ready` rises.
- Writeback with `wb_in_valid = 1`, wid=1, rd=3 during INIT -> `wb_in_ready = 0` until RUN, then it passes through in the first RUN cycle.
- Reset asserted mid-RUN with `rsp_valid = 1` -> `rsp_valid` is 0 immediately, the FSM returns to INIT, and the sweep restarts from address 0.
